instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 The module SHALL have parameter RD_LAT, default 1, legal range 1..4: RAM read latency in cycles, counted from the edge that samples er=1 to the edge at which data_out is valid to sample.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 address  out  8  RAM read address.
REQ-007 er  out  1  RAM read enable.
REQ-008 data_out  in  24  RAM read data.
REQ-009 start  in  1  begin fetching from the current PC.
REQ-010 halt  in  1  stop fetching.
REQ-011 jump  in  1  redirect PC to jump_addr.
REQ-012 jump_addr  in  8  jump target.
REQ-013 instr  out  24  fetched instruction.
REQ-014 instr_valid  out  1  instr and pc are valid.
REQ-015 instr_ready  in  1  consumer accepts instr.
REQ-016 pc  out  8  address of the instruction currently held or being fetched.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and HOLD.
REQ-018 In IDLE: er=0 and instr_valid=0; start=1 SHALL move the FSM to ISSUE.
REQ-019 In ISSUE: er=1 and address=pc for exactly one cycle, then WAIT.
REQ-020 In WAIT: er=0; the FSM SHALL stay RD_LAT cycles (RD_LAT=1 means one WAIT cycle), latch data_out into instr on the last WAIT edge, then enter HOLD.
REQ-021 In HOLD: instr_valid=1; instr and pc SHALL remain stable while instr_ready=0.
REQ-022 In HOLD with instr_ready=1: pc SHALL become pc+1 mod 256 (8'hFF wraps to 8'h00), instr_valid SHALL deassert next cycle, and the FSM SHALL enter ISSUE.
REQ-023 Latency SHALL be 3 cycles for RD_LAT=1: start sampled at edge N gives er=1 in cycle N+1 and instr_valid=1 in cycle N+3. Each extra RD_LAT cycle adds one cycle.
REQ-024 Sustained throughput with instr_ready held high SHALL be one instruction per RD_LAT+2 cycles.
REQ-025 jump=1 in ISSUE, WAIT or HOLD SHALL load pc=jump_addr, discard any in-flight or held instruction (instr_valid=0 next cycle), and enter ISSUE.
REQ-026 jump=1 in IDLE SHALL load pc=jump_addr and stay in IDLE.
REQ-027 halt=1 in any state SHALL enter IDLE next cycle, with er=0 and instr_valid=0.
REQ-028 On halt, pc SHALL be unchanged, so a restart refetches the unconsumed instruction.
REQ-029 Priority SHALL be rst > halt > jump > instr_ready handshake > start.
REQ-030 halt and jump in the same cycle SHALL load pc=jump_addr and enter IDLE.
REQ-031 jump and instr_ready in the same HOLD cycle: the handshake completes for the held instruction, but pc SHALL load jump_addr, not pc+1.
REQ-032 start while not in IDLE SHALL be ignored.
REQ-033 address SHALL hold the last issued value when er=0.

Reset
REQ-034 When rst=1 at an edge, the next state SHALL be: state=IDLE, pc=RESET_PC, address=8'h00, er=0, instr=24'h0, instr_valid=0, WAIT counter=0.
REQ-035 Reset mid-fetch SHALL abandon the outstanding read; a data_out value arriving after reset SHALL be ignored.

Structure
REQ-036 Package cpu8_pkg SHALL hold ADDR_W=8, INSTR_W=24 and the fetch state enum.
REQ-037 One sub-module, fetch_pc, SHALL implement the PC register with reset, load and increment.
REQ-038 The FSM and WAIT counter SHALL reside in instr_fetch.

Verification
REQ-039 Bench SHALL use a ram model with RD_LAT=1 preloaded with mem[n]=24'hA00000+n.
REQ-040 Reset then start with instr_ready=1: er pulses with address 0,1,2; instr 24'hA00000, 24'hA00001, 24'hA00002, each valid in its HOLD cycle; valid-to-valid spacing is 3 cycles.
REQ-041 Backpressure: instr_ready=0 for 5 cycles in HOLD at pc=4: instr=24'hA00004 and pc=4 stable, no er pulse; after instr_ready=1, next address=5.
REQ-042 Wrap: jump_addr=8'hFE, then consume 3 instructions: addresses 8'hFE, 8'hFF, 8'h00; pc wraps to 0.
REQ-043 Jump during WAIT to 8'h40: old data is not presented; next er has address=8'h40; instr=24'hA00040.
REQ-044 Halt in HOLD at pc=7, then start: er reissues address 7. Reset asserted in WAIT: all outputs return to reset values next cycle and instr_valid stays 0.

Source files
------------

// File: rtl/cpu8_pkg.sv
// Shared widths and fetch state encoding for the 8-bit CPU front end.
package cpu8_pkg;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned INSTR_W = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } fetch_state_e;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus: RAM read port, control inputs and the instruction handshake.
interface instr_fetch_if;
   import cpu8_pkg::*;

   logic [ADDR_W-1:0]  address;
   logic               er;
   logic [INSTR_W-1:0] data_out;
   logic               start;
   logic               halt;
   logic               jump;
   logic [ADDR_W-1:0]  jump_addr;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               instr_ready;
   logic [ADDR_W-1:0]  pc;

   modport master (
      output address, er, instr, instr_valid, pc,
      input  data_out, start, halt, jump, jump_addr, instr_ready
   );

   modport slave (
      input  address, er, instr, instr_valid, pc,
      output data_out, start, halt, jump, jump_addr, instr_ready
   );
endinterface

// File: rtl/fetch_pc.sv
// Program counter register: reset value, absolute load and wrapping increment.
module fetch_pc
   import cpu8_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_addr_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] pc_o
);
   logic [ADDR_W-1:0] pc_q, pc_d;

   // Load wins over increment so a jump on a completing handshake redirects.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_addr_i;
      end else if (inc_i) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: issues one RAM read per instruction and holds the
// result until the consumer accepts it.
module instr_fetch
   import cpu8_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
   parameter int unsigned       RD_LAT   = 1
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.master bus
);
   localparam int unsigned      CNT_W     = 2;
   localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(RD_LAT - 1);

   fetch_state_e       state_q, state_d;
   logic [CNT_W-1:0]   wcnt_q, wcnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  pc;
   logic               pc_load, pc_inc;

   fetch_pc #(
      .RESET_PC (RESET_PC)
   ) u_fetch_pc (
      .clk         (clk),
      .rst         (rst),
      .load_i      (pc_load),
      .load_addr_i (bus.jump_addr),
      .inc_i       (pc_inc),
      .pc_o        (pc)
   );

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      pc_load = 1'b0;
      pc_inc  = 1'b0;

      // The read was issued this cycle whatever happens next, so remember it.
      if (state_q == ISSUE) begin
         addr_d = pc;
      end

      if (bus.halt) begin
         pc_load = bus.jump;
         state_d = IDLE;
         wcnt_d  = '0;
      end else if (bus.jump) begin
         pc_load = 1'b1;
         state_d = (state_q == IDLE) ? IDLE : ISSUE;
         wcnt_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d = ISSUE;
               end
            end
            ISSUE: begin
               state_d = WAIT;
               wcnt_d  = '0;
            end
            WAIT: begin
               if (wcnt_q == WCNT_LAST) begin
                  instr_d = bus.data_out;
                  state_d = HOLD;
                  wcnt_d  = '0;
               end else begin
                  wcnt_d = wcnt_q + CNT_W'(1);
               end
            end
            HOLD: begin
               if (bus.instr_ready) begin
                  pc_inc  = 1'b1;
                  state_d = ISSUE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         addr_q  <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
      end
   end

   assign bus.er          = (state_q == ISSUE);
   assign bus.address     = (state_q == ISSUE) ? pc : addr_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = (state_q == HOLD);
   assign bus.pc          = pc;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a transaction-level reference model.
module tb_instr_fetch;
   localparam int unsigned RD_LAT = 1;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   instr_fetch_if bus ();

   instr_fetch #(
      .RESET_PC (8'h00),
      .RD_LAT   (RD_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // RAM with one cycle of read latency.
   logic [23:0] mem [256];
   logic [7:0]  ram_addr = 8'h00;
   initial for (int n = 0; n < 256; n++) mem[n] = 24'hA00000 + 24'(n);
   always @(posedge clk) if (bus.er) ram_addr <= bus.address;
   assign bus.data_out = mem[ram_addr];

   function automatic logic [23:0] word_at(logic [7:0] a);
      return 24'hA00000 + {16'h0, a};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a fetch is "busy" with an age counting cycles since its
   // issue; the result is visible at age RD_LAT+1 until accepted.
   bit          m_busy = 0;
   int          m_age = 0;
   logic [7:0]  m_pc = 8'h00, m_addr = 8'h00;
   logic [23:0] m_instr = 24'h0;

   task automatic model_step();
      bit issued;
      issued = m_busy && (m_age == 0);
      if (rst) begin
         m_busy = 0; m_age = 0; m_pc = 8'h00; m_addr = 8'h00; m_instr = 24'h0;
         return;
      end
      if (issued) m_addr = m_pc;
      if (bus.halt) begin
         if (bus.jump) m_pc = bus.jump_addr;
         m_busy = 0; m_age = 0;
      end else if (bus.jump) begin
         m_pc = bus.jump_addr; m_age = 0;
      end else if (!m_busy) begin
         if (bus.start) begin m_busy = 1; m_age = 0; end
      end else if (m_age == RD_LAT) begin
         m_instr = word_at(m_addr); m_age++;
      end else if (m_age == RD_LAT + 1) begin
         if (bus.instr_ready) begin m_pc++; m_age = 0; end
      end else begin
         m_age++;
      end
   endtask

   logic [7:0]  er_log [$];
   logic [23:0] hs_instr [$];
   int          hs_cyc [$];

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         cyc++;
         #1;
         chk("er", 32'(bus.er), 32'(m_busy && m_age == 0));
         chk("address", 32'(bus.address), 32'((m_busy && m_age == 0) ? m_pc : m_addr));
         chk("instr_valid", 32'(bus.instr_valid), 32'(m_busy && m_age == RD_LAT + 1));
         chk("pc", 32'(bus.pc), 32'(m_pc));
         chk("instr", 32'(bus.instr), 32'(m_instr));
         if (bus.er) er_log.push_back(bus.address);
         if (bus.instr_valid && bus.instr_ready && !bus.halt && !rst) begin
            hs_instr.push_back(bus.instr);
            hs_cyc.push_back(cyc);
         end
      end
   end

   task automatic wait_er(string tag);
      int n = 0;
      while (!bus.er && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (!bus.er) begin errors++; $display("FAIL %s: er not seen, got 0 expected 1", tag); end
   endtask

   task automatic wait_valid(string tag);
      int n = 0;
      while (!bus.instr_valid && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (!bus.instr_valid) begin errors++; $display("FAIL %s: instr_valid not seen, got 0 expected 1", tag); end
   endtask

   initial begin
      int base, n;
      rst = 1'b1;
      bus.start = 1'b0; bus.halt = 1'b0; bus.jump = 1'b0;
      bus.jump_addr = 8'h00; bus.instr_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_pc", 32'(bus.pc), 32'h00);
      chk("rst_er", 32'(bus.er), 32'h0);
      chk("rst_valid", 32'(bus.instr_valid), 32'h0);
      chk("rst_instr", 32'(bus.instr), 32'h0);
      chk("rst_addr", 32'(bus.address), 32'h00);
      rst = 1'b0;

      // Streaming fetch from reset with the consumer always ready.
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      chk("first_er", 32'(bus.er), 32'h1);
      chk("first_addr", 32'(bus.address), 32'h00);
      n = 0;
      while (hs_instr.size() < 3 && n < 40) begin @(negedge clk); n++; end
      chk("stream_count", 32'(hs_instr.size()), 32'd3);
      if (hs_instr.size() >= 3) begin
         chk("stream_i0", 32'(hs_instr[0]), 32'hA00000);
         chk("stream_i1", 32'(hs_instr[1]), 32'hA00001);
         chk("stream_i2", 32'(hs_instr[2]), 32'hA00002);
         chk("spacing01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
         chk("spacing12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
         chk("er_addrs", {8'h0, er_log[0], er_log[1], er_log[2]}, 32'h00000102);
      end

      // Backpressure while holding pc=4.
      n = 0;
      while (!(bus.instr_valid && bus.pc == 8'h04) && n < 40) begin @(negedge clk); n++; end
      bus.instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_instr", 32'(bus.instr), 32'hA00004);
         chk("bp_pc", 32'(bus.pc), 32'h04);
         chk("bp_er", 32'(bus.er), 32'h0);
         chk("bp_valid", 32'(bus.instr_valid), 32'h1);
      end
      bus.instr_ready = 1'b1;
      @(negedge clk);
      wait_er("bp_resume");
      chk("bp_next_addr", 32'(bus.address), 32'h05);

      // Redirect to 0xFE and let the pc wrap.
      bus.jump = 1'b1; bus.jump_addr = 8'hFE;
      base = er_log.size();
      @(negedge clk); bus.jump = 1'b0;
      n = 0;
      while (er_log.size() < base + 3 && n < 40) begin @(negedge clk); n++; end
      chk("wrap_count", 32'(er_log.size() - base), 32'd3);
      if (er_log.size() >= base + 3) begin
         chk("wrap_a0", 32'(er_log[base]), 32'hFE);
         chk("wrap_a1", 32'(er_log[base + 1]), 32'hFF);
         chk("wrap_a2", 32'(er_log[base + 2]), 32'h00);
      end
      chk("wrap_pc", 32'(bus.pc), 32'h00);

      // Jump while the read is in flight.
      wait_er("jw_issue");
      @(negedge clk);
      chk("jw_in_wait", 32'(bus.er), 32'h0);
      bus.jump = 1'b1; bus.jump_addr = 8'h40;
      @(negedge clk); bus.jump = 1'b0;
      chk("jw_valid", 32'(bus.instr_valid), 32'h0);
      chk("jw_er", 32'(bus.er), 32'h1);
      chk("jw_addr", 32'(bus.address), 32'h40);
      @(negedge clk);
      wait_valid("jw_result");
      chk("jw_instr", 32'(bus.instr), 32'hA00040);
      chk("jw_pc", 32'(bus.pc), 32'h40);

      // Halt while holding pc=7, then restart.
      bus.instr_ready = 1'b0;
      bus.jump = 1'b1; bus.jump_addr = 8'h07;
      @(negedge clk); bus.jump = 1'b0;
      @(negedge clk);
      wait_valid("halt_hold");
      chk("halt_pc_before", 32'(bus.pc), 32'h07);
      bus.halt = 1'b1;
      @(negedge clk); bus.halt = 1'b0;
      chk("halt_valid", 32'(bus.instr_valid), 32'h0);
      chk("halt_er", 32'(bus.er), 32'h0);
      chk("halt_pc", 32'(bus.pc), 32'h07);
      @(negedge clk);
      chk("halt_idle_er", 32'(bus.er), 32'h0);
      bus.start = 1'b1; bus.instr_ready = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      chk("restart_er", 32'(bus.er), 32'h1);
      chk("restart_addr", 32'(bus.address), 32'h07);
      @(negedge clk);
      wait_valid("restart_result");
      chk("restart_instr", 32'(bus.instr), 32'hA00007);

      // Reset in the middle of a read.
      wait_er("rst_issue");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("mid_rst_pc", 32'(bus.pc), 32'h00);
      chk("mid_rst_er", 32'(bus.er), 32'h0);
      chk("mid_rst_valid", 32'(bus.instr_valid), 32'h0);
      chk("mid_rst_instr", 32'(bus.instr), 32'h0);
      chk("mid_rst_addr", 32'(bus.address), 32'h00);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_valid", 32'(bus.instr_valid), 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
